// File: rtl/load_align_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_align_unit
//  Description : Multicycle load path. Issues one or two word reads to data
//                memory, extracts the addressed byte/half/word at any byte
//                offset, sign- or zero-extends it and returns it over a
//                valid/ready handshake with an error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align_unit #(
   parameter int DATA_W          = 32,
   parameter int ADDR_W          = 32,
   parameter int MEM_LAT         = 1,
   parameter int ALLOW_UNALIGNED = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err
);

   // Counter holds MEM_LAT-1, so clog2(MEM_LAT) bits suffice (min 1 bit).
   localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD0   = 3'd1,
      S_WAIT0 = 3'd2,
      S_RD1   = 3'd3,
      S_WAIT1 = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   state_t              state_q,    state_d;
   logic [1:0]          off_q,      off_d;
   logic [1:0]          size_q,     size_d;
   logic                signed_q,   signed_d;
   logic [CNT_W-1:0]    cnt_q,      cnt_d;
   logic [DATA_W-1:0]   lo_q,       lo_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_err_q,  rsp_err_d;

   logic                req_illegal;
   logic                crossing;

   // Shift the {high,low} word pair right by the byte offset, keep the access
   // width and extend from its top bit when signed.
   function automatic logic [DATA_W-1:0] extract(input logic [2*DATA_W-1:0] pair,
                                                 input logic [1:0] off,
                                                 input logic [1:0] size,
                                                 input logic       sgn);
      logic [DATA_W-1:0] shifted;
      logic [DATA_W-1:0] res;
      shifted = DATA_W'(pair >> {off, 3'b000});
      case (size)
         2'd1:    res = {{(DATA_W-8){sgn & shifted[7]}}, shifted[7:0]};
         2'd2:    res = {{(DATA_W-16){sgn & shifted[15]}}, shifted[15:0]};
         default: res = shifted;
      endcase
      return res;
   endfunction

   // Request legality: size 0 is never legal; misaligned accesses are only
   // legal when the unit is allowed to merge two reads.
   always_comb begin
      req_illegal = 1'b0;
      if (req_size == 2'd0) begin
         req_illegal = 1'b1;
      end else if (ALLOW_UNALIGNED == 0) begin
         if ((req_size == 2'd2) && req_addr[0])
            req_illegal = 1'b1;
         if ((req_size == 2'd3) && (req_addr[1:0] != 2'b00))
            req_illegal = 1'b1;
      end
   end

   // A latched access crosses into the next word for half@3 and word@1..3.
   always_comb begin
      crossing = 1'b0;
      if ((size_q == 2'd2) && (off_q == 2'd3))
         crossing = 1'b1;
      if ((size_q == 2'd3) && (off_q != 2'd0))
         crossing = 1'b1;
   end

   // Next-state logic: accept, issue reads, capture data, present response.
   always_comb begin
      state_d    = state_q;
      off_d      = off_q;
      size_d     = size_q;
      signed_d   = signed_q;
      cnt_d      = cnt_q;
      lo_d       = lo_q;
      mem_addr_d = mem_addr_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               off_d    = req_addr[1:0];
               size_d   = req_size;
               signed_d = req_signed;
               if (req_illegal) begin
                  rsp_err_d  = 1'b1;
                  rsp_data_d = '0;
                  state_d    = S_RESP;
               end else begin
                  rsp_err_d  = 1'b0;
                  mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                  state_d    = S_RD0;
               end
            end
         end
         S_RD0: begin
            cnt_d   = CNT_LOAD;
            state_d = S_WAIT0;
         end
         S_WAIT0: begin
            if (cnt_q == '0) begin
               lo_d = mem_rdata;
               if (crossing) begin
                  // Next word address is prepared here so it is on the bus in RD1.
                  mem_addr_d = mem_addr_q + ADDR_W'(4);
                  state_d    = S_RD1;
               end else begin
                  rsp_data_d = extract({{DATA_W{1'b0}}, mem_rdata}, off_q, size_q, signed_q);
                  state_d    = S_RESP;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RD1: begin
            cnt_d   = CNT_LOAD;
            state_d = S_WAIT1;
         end
         S_WAIT1: begin
            if (cnt_q == '0) begin
               rsp_data_d = extract({mem_rdata, lo_q}, off_q, size_q, signed_q);
               state_d    = S_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any read in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         off_q      <= '0;
         size_q     <= '0;
         signed_q   <= 1'b0;
         cnt_q      <= '0;
         lo_q       <= '0;
         mem_addr_q <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         off_q      <= off_d;
         size_q     <= size_d;
         signed_q   <= signed_d;
         cnt_q      <= cnt_d;
         lo_q       <= lo_d;
         mem_addr_q <= mem_addr_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign mem_rd    = (state_q == S_RD0) || (state_q == S_RD1);
   assign mem_addr  = mem_addr_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_load_align_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_align_unit
//  Description : Directed self-checking bench. Unit 0: MEM_LAT=1 unaligned
//                allowed; unit 1: MEM_LAT=1 unaligned rejected; unit 2:
//                MEM_LAT=3 unaligned allowed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_align_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid  [3];
   logic [31:0] req_addr   [3];
   logic [1:0]  req_size   [3];
   logic        req_signed [3];
   logic        rsp_ready  [3];
   logic [31:0] mem_rdata  [3];
   wire         req_ready  [3];
   wire         mem_rd     [3];
   wire  [31:0] mem_addr   [3];
   wire         rsp_valid  [3];
   wire  [31:0] rsp_data   [3];
   wire         rsp_err    [3];

   int          rd_total   [3];
   logic [31:0] rd_last    [3];
   logic [31:0] rd_prev    [3];
   int          consec     [3];
   logic        prev_rd    [3];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h100: return 32'h8899AABB;
         32'h104: return 32'h11223344;
         default: return a ^ 32'hA5A5A5A5;
      endcase
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_unit
      localparam int L = (g == 2) ? 3 : 1;
      logic [31:0] pa [4];
      logic        pv [4];

      load_align_unit #(
         .DATA_W(32), .ADDR_W(32), .MEM_LAT(L), .ALLOW_UNALIGNED((g == 1) ? 0 : 1)
      ) u_dut (
         .clk(clk), .reset_n(reset_n),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]),
         .req_addr(req_addr[g]), .req_size(req_size[g]), .req_signed(req_signed[g]),
         .mem_rd(mem_rd[g]), .mem_addr(mem_addr[g]), .mem_rdata(mem_rdata[g]),
         .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
         .rsp_data(rsp_data[g]), .rsp_err(rsp_err[g])
      );

      // Memory: data valid exactly L cycles after the strobe, garbage otherwise.
      always @(posedge clk) begin
         pv[0] <= mem_rd[g];
         pa[0] <= mem_addr[g];
         for (int k = 1; k < 4; k++) begin
            pv[k] <= pv[k-1];
            pa[k] <= pa[k-1];
         end
      end
      assign mem_rdata[g] = (pv[L-1] === 1'b1) ? mem_word(pa[L-1]) : 32'hDEADBEEF;

      initial begin
         rd_total[g] = 0; consec[g] = 0; prev_rd[g] = 1'b0;
         rd_last[g] = '0; rd_prev[g] = '0;
         for (int k = 0; k < 4; k++) begin pv[k] = 1'b0; pa[k] = '0; end
      end

      // Read strobe monitor.
      always @(negedge clk) begin
         if (mem_rd[g] === 1'b1) begin
            rd_prev[g]  = rd_last[g];
            rd_last[g]  = mem_addr[g];
            rd_total[g] = rd_total[g] + 1;
            if (prev_rd[g] === 1'b1) consec[g] = consec[g] + 1;
         end
         prev_rd[g] = mem_rd[g];
      end
   end

   // Wait for rsp_valid starting just after the accept edge, then handshake.
   task automatic wait_rsp(input int u, output logic [31:0] data, output logic err, output int lat);
      lat  = 1;
      data = '0;
      err  = 1'b0;
      forever begin
         @(negedge clk);
         if (rsp_valid[u] === 1'b1) break;
         if (lat >= 40) begin
            checks++; failures++;
            $display("FAIL timeout unit %0d: rsp_valid not seen after %0d cycles, required within 40", u, lat);
            lat = -1;
            return;
         end
         @(posedge clk);
         lat++;
      end
      data = rsp_data[u];
      err  = rsp_err[u];
      rsp_ready[u] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[u] = 1'b0;
   endtask

   // Present a request, wait for accept, collect the response.
   task automatic do_load(input int u, input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                          output logic [31:0] data, output logic err, output int lat);
      int n;
      req_addr[u] = addr; req_size[u] = size; req_signed[u] = sgn; req_valid[u] = 1'b1;
      n = 0;
      @(negedge clk);
      while (req_ready[u] !== 1'b1) begin
         if (n >= 20) begin
            checks++; failures++;
            $display("FAIL timeout unit %0d: req_ready low for 20 cycles, required high", u);
            req_valid[u] = 1'b0; data = '0; err = 1'b0; lat = -1;
            return;
         end
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      req_valid[u] = 1'b0;
      wait_rsp(u, data, err, lat);
   endtask

   task automatic test_reset();
      for (int u = 0; u < 3; u++) begin
         checks++;
         if ({req_ready[u], rsp_valid[u], mem_rd[u], mem_addr[u], rsp_data[u], rsp_err[u]} !==
             {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset unit %0d: rdy=%b vld=%b rd=%b maddr=%h data=%h err=%b, required 1 0 0 0 0 0",
                     u, req_ready[u], rsp_valid[u], mem_rd[u], mem_addr[u], rsp_data[u], rsp_err[u]);
         end
      end
   endtask

   task automatic test_byte();
      logic [31:0] d; logic e; int lat; int base;
      base = rd_total[0];
      do_load(0, 32'h100, 2'd1, 1'b1, d, e, lat);
      checks++; if ({e, d} !== {1'b0, 32'hFFFFFFBB}) begin failures++;
         $display("FAIL byte_s_100: err=%b data=%h, required 0 ffffffbb", e, d); end
      checks++; if (lat != 3) begin failures++;
         $display("FAIL byte_latency: got %0d, required 3", lat); end
      checks++; if (rd_total[0] - base != 1 || rd_last[0] !== 32'h100) begin failures++;
         $display("FAIL byte_reads: count=%0d addr=%h, required 1 00000100", rd_total[0] - base, rd_last[0]); end
      do_load(0, 32'h102, 2'd1, 1'b0, d, e, lat);
      checks++; if (d !== 32'h00000099) begin failures++;
         $display("FAIL byte_u_102: got %h, required 00000099", d); end
   endtask

   task automatic test_half_word();
      logic [31:0] d; logic e; int lat;
      do_load(0, 32'h102, 2'd2, 1'b1, d, e, lat);
      checks++; if (d !== 32'hFFFF8899) begin failures++;
         $display("FAIL half_s_102: got %h, required ffff8899", d); end
      do_load(0, 32'h102, 2'd2, 1'b0, d, e, lat);
      checks++; if (d !== 32'h00008899) begin failures++;
         $display("FAIL half_u_102: got %h, required 00008899", d); end
      do_load(0, 32'h101, 2'd2, 1'b0, d, e, lat);
      checks++; if ({e, d, 8'(lat)} !== {1'b0, 32'h000099AA, 8'd3}) begin failures++;
         $display("FAIL half_u_101: err=%b data=%h lat=%0d, required 0 000099aa 3", e, d, lat); end
      do_load(0, 32'h104, 2'd3, 1'b1, d, e, lat);
      checks++; if (d !== 32'h11223344) begin failures++;
         $display("FAIL word_104: got %h, required 11223344", d); end
   endtask

   task automatic test_unaligned();
      logic [31:0] d; logic e; int lat; int base;
      base = rd_total[0];
      do_load(0, 32'h103, 2'd3, 1'b0, d, e, lat);
      checks++; if ({e, d} !== {1'b0, 32'h22334488}) begin failures++;
         $display("FAIL word_103: err=%b data=%h, required 0 22334488", e, d); end
      checks++; if (lat != 5) begin failures++;
         $display("FAIL word_103_latency: got %0d, required 5", lat); end
      checks++; if (rd_total[0] - base != 2 || rd_prev[0] !== 32'h100 || rd_last[0] !== 32'h104) begin failures++;
         $display("FAIL word_103_reads: count=%0d first=%h second=%h, required 2 00000100 00000104",
                  rd_total[0] - base, rd_prev[0], rd_last[0]); end
      do_load(0, 32'h103, 2'd2, 1'b1, d, e, lat);
      checks++; if (d !== 32'h00004488) begin failures++;
         $display("FAIL half_s_103: got %h, required 00004488", d); end
      do_load(0, 32'hFFFFFFFE, 2'd3, 1'b0, d, e, lat);
      checks++; if (rd_prev[0] !== 32'hFFFFFFFC || rd_last[0] !== 32'h0) begin failures++;
         $display("FAIL wrap_reads: first=%h second=%h, required fffffffc 00000000", rd_prev[0], rd_last[0]); end
   endtask

   task automatic test_errors();
      logic [31:0] d; logic e; int lat; int base;
      base = rd_total[1];
      do_load(1, 32'h101, 2'd2, 1'b0, d, e, lat);
      checks++; if ({e, d, 8'(lat)} !== {1'b1, 32'h0, 8'd1}) begin failures++;
         $display("FAIL err_half_101: err=%b data=%h lat=%0d, required 1 00000000 1", e, d, lat); end
      checks++; if (rd_total[1] != base) begin failures++;
         $display("FAIL err_no_read: reads=%0d, required 0", rd_total[1] - base); end
      do_load(1, 32'h103, 2'd1, 1'b1, d, e, lat);
      checks++; if ({e, d} !== {1'b0, 32'hFFFFFF88}) begin failures++;
         $display("FAIL strict_byte_103: err=%b data=%h, required 0 ffffff88", e, d); end
      do_load(1, 32'h103, 2'd3, 1'b0, d, e, lat);
      checks++; if ({e, d} !== {1'b1, 32'h0}) begin failures++;
         $display("FAIL err_word_103: err=%b data=%h, required 1 00000000", e, d); end
      do_load(1, 32'h104, 2'd3, 1'b0, d, e, lat);
      checks++; if ({e, d} !== {1'b0, 32'h11223344}) begin failures++;
         $display("FAIL strict_word_104: err=%b data=%h, required 0 11223344", e, d); end
      do_load(0, 32'h100, 2'd0, 1'b0, d, e, lat);
      checks++; if ({e, d, 8'(lat)} !== {1'b1, 32'h0, 8'd1}) begin failures++;
         $display("FAIL err_size0: err=%b data=%h lat=%0d, required 1 00000000 1", e, d, lat); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d; logic e; int lat; int bad;
      req_addr[0] = 32'h100; req_size[0] = 2'd1; req_signed[0] = 1'b1; req_valid[0] = 1'b1;
      @(posedge clk); #1;
      // Second request stays pending while the first response is stalled.
      req_addr[0] = 32'h104; req_size[0] = 2'd3; req_signed[0] = 1'b0;
      bad = 0;
      repeat (2) @(posedge clk);
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'hFFFFFFBB || req_ready[0] !== 1'b0) bad++;
         @(posedge clk);
      end
      checks++; if (bad != 0) begin failures++;
         $display("FAIL stall_hold: %0d unstable cycles, required 0", bad); end
      @(negedge clk);
      rsp_ready[0] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[0] = 1'b0;
      @(negedge clk);
      checks++; if ({req_ready[0], rsp_valid[0]} !== 2'b10) begin failures++;
         $display("FAIL after_handshake: ready=%b valid=%b, required 1 0", req_ready[0], rsp_valid[0]); end
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      wait_rsp(0, d, e, lat);
      checks++; if ({e, d, 8'(lat)} !== {1'b0, 32'h11223344, 8'd3}) begin failures++;
         $display("FAIL second_req: err=%b data=%h lat=%0d, required 0 11223344 3", e, d, lat); end
   endtask

   task automatic test_lat3();
      logic [31:0] d; logic e; int lat;
      do_load(2, 32'h100, 2'd1, 1'b1, d, e, lat);
      checks++; if ({d, 8'(lat)} !== {32'hFFFFFFBB, 8'd5}) begin failures++;
         $display("FAIL lat3_byte: data=%h lat=%0d, required ffffffbb 5", d, lat); end
      do_load(2, 32'h102, 2'd2, 1'b0, d, e, lat);
      checks++; if ({d, 8'(lat)} !== {32'h00008899, 8'd5}) begin failures++;
         $display("FAIL lat3_half: data=%h lat=%0d, required 00008899 5", d, lat); end
      do_load(2, 32'h103, 2'd3, 1'b0, d, e, lat);
      checks++; if ({d, 8'(lat)} !== {32'h22334488, 8'd9}) begin failures++;
         $display("FAIL lat3_cross: data=%h lat=%0d, required 22334488 9", d, lat); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic e; int lat; int seen;
      req_addr[0] = 32'h103; req_size[0] = 2'd3; req_signed[0] = 1'b0; req_valid[0] = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(negedge clk);      // RD0
      @(negedge clk);      // WAIT0
      reset_n = 1'b0;
      #1;
      checks++;
      if ({req_ready[0], rsp_valid[0], mem_rd[0], mem_addr[0], rsp_data[0], rsp_err[0]} !==
          {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
         failures++;
         $display("FAIL mid_reset: rdy=%b vld=%b rd=%b maddr=%h data=%h err=%b, required 1 0 0 0 0 0",
                  req_ready[0], rsp_valid[0], mem_rd[0], mem_addr[0], rsp_data[0], rsp_err[0]);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid[0] === 1'b1 || mem_rd[0] === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin failures++;
         $display("FAIL post_reset_quiet: %0d active cycles, required 0", seen); end
      @(posedge clk); #1;
      do_load(0, 32'h103, 2'd3, 1'b0, d, e, lat);
      checks++; if ({e, d, 8'(lat)} !== {1'b0, 32'h22334488, 8'd5}) begin failures++;
         $display("FAIL post_reset_load: err=%b data=%h lat=%0d, required 0 22334488 5", e, d, lat); end
   endtask

   initial begin
      reset_n = 1'b0;
      for (int u = 0; u < 3; u++) begin
         req_valid[u] = 1'b0; req_addr[u] = '0; req_size[u] = '0;
         req_signed[u] = 1'b0; rsp_ready[u] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      test_reset();
      reset_n = 1'b1;
      @(posedge clk); #1;
      test_byte();
      test_half_word();
      test_unaligned();
      test_errors();
      test_back_to_back();
      test_lat3();
      test_reset_mid();
      checks++;
      if (consec[0] + consec[1] + consec[2] != 0) begin
         failures++;
         $display("FAIL mem_rd_consecutive: %0d back-to-back strobes, required 0",
                  consec[0] + consec[1] + consec[2]);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
